// File: rtl/screen_scheduler.sv
// Round-robin display scheduler sharing one 16-bit hex screen between four
// sources. Advances on a dwell timer or a step pulse; a pin override locks
// the display onto a chosen source. All outputs are registered.
module screen_scheduler #(
    parameter int unsigned DWELL_CYCLES = 12_000_000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  src_valid,
    input  logic [63:0] src_data,
    input  logic        step,
    input  logic        pin_en,
    input  logic [1:0]  pin_sel,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic [1:0]  cur_sel,
    output logic        switch_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        PINNED
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             nv_found;
    logic [1:0]       nv_idx;
    logic [1:0]       first_idx;
    logic             cur_valid;
    logic             cnt_expired;
    logic [15:0]      cur_word;
    logic [15:0]      pin_word;
    logic [15:0]      first_word;
    logic [15:0]      nv_word;

    assign cur_valid   = src_valid[cur_sel];
    assign cnt_expired = (cnt == CNT_W'(DWELL_CYCLES - 1));
    assign cur_word    = src_data[{cur_sel,   4'b0000} +: 16];
    assign pin_word    = src_data[{pin_sel,   4'b0000} +: 16];
    assign first_word  = src_data[{first_idx, 4'b0000} +: 16];
    assign nv_word     = src_data[{nv_idx,    4'b0000} +: 16];

    // Next valid source after cur_sel; scanning far-to-near lets the nearest win.
    always_comb begin
        nv_found = 1'b0;
        nv_idx   = cur_sel;
        for (int unsigned k = 3; k >= 1; k--) begin
            if (src_valid[cur_sel + 2'(k)]) begin
                nv_found = 1'b1;
                nv_idx   = cur_sel + 2'(k);
            end
        end
    end

    // Lowest-index valid source, used when leaving IDLE.
    always_comb begin
        first_idx = '0;
        for (int unsigned i = 4; i >= 1; i--) begin
            if (src_valid[i-1]) begin
                first_idx = 2'(i - 1);
            end
        end
    end

    // Scheduler FSM with registered display outputs and dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            cur_sel      <= '0;
            switch_pulse <= 1'b0;
        end else begin
            switch_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pin_en) begin
                        state        <= PINNED;
                        cur_sel      <= pin_sel;
                        dout         <= pin_word;
                        dout_valid   <= 1'b1;
                        cnt          <= '0;
                        switch_pulse <= (pin_sel != cur_sel);
                    end else if (|src_valid) begin
                        state        <= SHOW;
                        cur_sel      <= first_idx;
                        dout         <= first_word;
                        dout_valid   <= 1'b1;
                        cnt          <= '0;
                        switch_pulse <= 1'b1;
                    end else begin
                        dout_valid   <= 1'b0;
                    end
                end
                SHOW: begin
                    if (pin_en) begin
                        state        <= PINNED;
                        cur_sel      <= pin_sel;
                        dout         <= pin_word;
                        dout_valid   <= 1'b1;
                        cnt          <= '0;
                        switch_pulse <= (pin_sel != cur_sel);
                    end else if (!cur_valid) begin
                        // No next_valid here means nothing is valid at all.
                        if (nv_found) begin
                            cur_sel      <= nv_idx;
                            dout         <= nv_word;
                            dout_valid   <= 1'b1;
                            cnt          <= '0;
                            switch_pulse <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            dout_valid   <= 1'b0;
                            cnt          <= '0;
                        end
                    end else if (cnt_expired || step) begin
                        dout_valid <= 1'b1;
                        cnt        <= '0;
                        if (nv_found) begin
                            cur_sel      <= nv_idx;
                            dout         <= nv_word;
                            switch_pulse <= 1'b1;
                        end else begin
                            dout         <= cur_word;
                        end
                    end else begin
                        dout_valid <= 1'b1;
                        dout       <= cur_word;
                        cnt        <= cnt + CNT_W'(1);
                    end
                end
                PINNED: begin
                    cnt        <= '0;
                    dout_valid <= 1'b1;
                    if (pin_en) begin
                        cur_sel      <= pin_sel;
                        dout         <= pin_word;
                        switch_pulse <= (pin_sel != cur_sel);
                    end else begin
                        state <= SHOW;
                        dout  <= cur_word;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_scheduler.sv
// Self-checking bench for screen_scheduler with DWELL_CYCLES=4: directed
// scenarios against constants plus randomized traffic against a reference model.
module tb_screen_scheduler;

    localparam int DWELL = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  src_valid;
    logic [63:0] src_data;
    logic        step;
    logic        pin_en;
    logic [1:0]  pin_sel;
    logic [15:0] dout;
    logic        dout_valid;
    logic [1:0]  cur_sel;
    logic        switch_pulse;

    int n_pass  = 0;
    int n_total = 0;

    screen_scheduler #(
        .DWELL_CYCLES(DWELL),
        .CNT_W       (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .step        (step),
        .pin_en      (pin_en),
        .pin_sel     (pin_sel),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .cur_sel     (cur_sel),
        .switch_pulse(switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = blank, 1 = rotating, 2 = pinned.
    int          m_mode;
    int          m_sel;
    int          m_age;
    logic [15:0] m_dout;
    logic        m_dv;
    logic        m_pulse;

    function automatic logic [15:0] word_of(input int j);
        return src_data[16*j +: 16];
    endfunction

    function automatic void model_reset();
        m_mode  = 0;
        m_sel   = 0;
        m_age   = 0;
        m_dout  = 16'h0000;
        m_dv    = 1'b0;
        m_pulse = 1'b0;
    endfunction

    function automatic void model_show(input int j, input bit pulse);
        m_sel   = j;
        m_dout  = word_of(j);
        m_dv    = 1'b1;
        m_age   = 0;
        m_pulse = pulse;
    endfunction

    function automatic void model_edge();
        int nv;
        int low;
        nv  = -1;
        low = -1;
        for (int k = 1; k <= 3; k++)
            if (nv < 0 && src_valid[(m_sel + k) % 4]) nv = (m_sel + k) % 4;
        for (int i = 0; i < 4; i++)
            if (low < 0 && src_valid[i]) low = i;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_pulse = 1'b0;
        if (m_mode == 2 && !pin_en) begin
            m_mode = 1;
            m_dout = word_of(m_sel);
            m_age  = 0;
        end else if (pin_en) begin
            model_show(int'(pin_sel), (int'(pin_sel) != m_sel));
            m_mode = 2;
        end else if (m_mode == 0) begin
            if (low >= 0) begin
                model_show(low, 1'b1);
                m_mode = 1;
            end else begin
                m_dv = 1'b0;
            end
        end else if (!src_valid[m_sel]) begin
            if (nv >= 0) begin
                model_show(nv, 1'b1);
            end else begin
                m_mode = 0;
                m_dv   = 1'b0;
                m_age  = 0;
            end
        end else if (m_age == DWELL - 1 || step) begin
            if (nv >= 0) model_show(nv, 1'b1);
            else begin
                m_dout = word_of(m_sel);
                m_age  = 0;
            end
        end else begin
            m_dout = word_of(m_sel);
            m_age  = m_age + 1;
        end
    endfunction

    // Advance one clock; the model consumes the inputs the DUT is about to sample.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        src_valid = 4'b0000;
        src_data  = '0;
        step      = 1'b0;
        pin_en    = 1'b0;
        pin_sel   = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({dout, dout_valid, cur_sel, switch_pulse} !== 20'h0) begin
            $display("FAIL reset_values: got dout=%h dv=%b sel=%0d pulse=%b, want all zero",
                     dout, dout_valid, cur_sel, switch_pulse);
        end else n_pass++;
        tick();
        n_total++;
        if (dout_valid !== 1'b0 || switch_pulse !== 1'b0) begin
            $display("FAIL idle_no_source: got dv=%b pulse=%b, want 0 0", dout_valid, switch_pulse);
        end else n_pass++;
    endtask

    task automatic test_rotation();
        int          exp_sel [4] = '{0, 1, 3, 0};
        logic [15:0] exp_dat [4] = '{16'h1111, 16'h2222, 16'h4444, 16'h1111};
        int          bad;
        do_reset();
        src_valid = 4'b1011;
        src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bad = 0;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (cur_sel !== 2'(exp_sel[t/4]) || dout !== exp_dat[t/4] ||
                switch_pulse !== ((t % 4) == 0) || dout_valid !== 1'b1) begin
                $display("FAIL rotation_t%0d: got sel=%0d dout=%h pulse=%b dv=%b, want sel=%0d dout=%h pulse=%b dv=1",
                         t, cur_sel, dout, switch_pulse, dout_valid, exp_sel[t/4], exp_dat[t/4], (t % 4) == 0);
                bad++;
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL rotation_sequence: got %0d bad cycles, want 0", bad);
        else n_pass++;
    endtask

    task automatic test_step();
        int pulses;
        do_reset();
        src_valid = 4'b0100;
        src_data  = {16'hD0D0, 16'hC0C0, 16'hB0B0, 16'hA0A0};
        tick();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step = (i % 2 == 0);
            tick();
            if (switch_pulse) pulses++;
        end
        step = 1'b0;
        n_total++;
        if (cur_sel !== 2'd2 || pulses != 0) begin
            $display("FAIL step_single_source: got sel=%0d pulses=%0d, want sel=2 pulses=0", cur_sel, pulses);
        end else n_pass++;
        src_valid = 4'b0110;
        step      = 1'b1;
        tick();
        step = 1'b0;
        n_total++;
        if (cur_sel !== 2'd1 || switch_pulse !== 1'b1 || dout !== 16'hB0B0) begin
            $display("FAIL step_advance: got sel=%0d pulse=%b dout=%h, want sel=1 pulse=1 dout=b0b0",
                     cur_sel, switch_pulse, dout);
        end else n_pass++;
        tick();
        n_total++;
        if (switch_pulse !== 1'b0) $display("FAIL step_pulse_width: got pulse=%b, want 0", switch_pulse);
        else n_pass++;
    endtask

    task automatic test_invalidation();
        do_reset();
        src_valid = 4'b0011;
        src_data  = {16'h0, 16'h0, 16'h2222, 16'h1111};
        for (int i = 0; i < 6; i++) tick();
        n_total++;
        if (cur_sel !== 2'd1) $display("FAIL inval_setup: got sel=%0d, want 1", cur_sel);
        else n_pass++;
        src_valid = 4'b0001;
        tick();
        n_total++;
        if (cur_sel !== 2'd0 || switch_pulse !== 1'b1 || dout !== 16'h1111) begin
            $display("FAIL inval_switch: got sel=%0d pulse=%b dout=%h, want sel=0 pulse=1 dout=1111",
                     cur_sel, switch_pulse, dout);
        end else n_pass++;
        src_valid = 4'b0000;
        src_data  = {16'h0, 16'h0, 16'h2222, 16'h9999};
        tick();
        n_total++;
        if (dout_valid !== 1'b0 || dout !== 16'h1111 || switch_pulse !== 1'b0) begin
            $display("FAIL inval_idle: got dv=%b dout=%h pulse=%b, want dv=0 dout=1111 pulse=0",
                     dout_valid, dout, switch_pulse);
        end else n_pass++;
    endtask

    task automatic test_pin();
        int moves;
        do_reset();
        src_valid = 4'b1011;
        src_data  = {16'h4444, 16'hCCCC, 16'h2222, 16'h1111};
        tick();
        pin_en  = 1'b1;
        pin_sel = 2'd2;
        tick();
        n_total++;
        if (cur_sel !== 2'd2 || dout !== 16'hCCCC || dout_valid !== 1'b1 || switch_pulse !== 1'b1) begin
            $display("FAIL pin_enter: got sel=%0d dout=%h dv=%b pulse=%b, want sel=2 dout=cccc dv=1 pulse=1",
                     cur_sel, dout, dout_valid, switch_pulse);
        end else n_pass++;
        moves = 0;
        for (int i = 0; i < 20; i++) begin
            step = (i == 7);
            tick();
            if (cur_sel !== 2'd2 || switch_pulse !== 1'b0) moves++;
        end
        step = 1'b0;
        n_total++;
        if (moves != 0) $display("FAIL pin_hold: got %0d moved cycles, want 0", moves);
        else n_pass++;
        pin_en = 1'b0;
        tick();
        tick();
        n_total++;
        if (cur_sel !== 2'd3 || dout !== 16'h4444) begin
            $display("FAIL pin_release: got sel=%0d dout=%h, want sel=3 dout=4444", cur_sel, dout);
        end else n_pass++;
    endtask

    task automatic test_live_data();
        do_reset();
        src_valid = 4'b0001;
        src_data  = {48'h0, 16'h1234};
        tick();
        tick();
        src_data = {48'h0, 16'hBEEF};
        #1;
        n_total++;
        if (dout !== 16'h1234) $display("FAIL live_no_comb: got dout=%h, want 1234", dout);
        else n_pass++;
        tick();
        n_total++;
        if (dout !== 16'hBEEF || cur_sel !== 2'd0) begin
            $display("FAIL live_track: got dout=%h sel=%0d, want beef sel=0", dout, cur_sel);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        src_valid = 4'b1011;
        src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({dout, dout_valid, cur_sel, switch_pulse} !== 20'h0) begin
            $display("FAIL async_reset: got dout=%h dv=%b sel=%0d pulse=%b, want all zero",
                     dout, dout_valid, cur_sel, switch_pulse);
        end else n_pass++;
        src_valid = 4'b1000;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if (cur_sel !== 2'd3 || dout !== 16'h4444 || dout_valid !== 1'b1 || switch_pulse !== 1'b1) begin
            $display("FAIL reset_release: got sel=%0d dout=%h dv=%b pulse=%b, want sel=3 dout=4444 dv=1 pulse=1",
                     cur_sel, dout, dout_valid, switch_pulse);
        end else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) src_valid = 4'($urandom);
            if ($urandom_range(0, 3) == 0) src_data = {$urandom, $urandom};
            step = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) pin_en = ~pin_en;
            if ($urandom_range(0, 4) == 0) pin_sel = 2'($urandom);
            tick();
            n_total++;
            if (dout !== m_dout || dout_valid !== m_dv || cur_sel !== 2'(m_sel) || switch_pulse !== m_pulse) begin
                $display("FAIL random_c%0d: got dout=%h dv=%b sel=%0d pulse=%b, want dout=%h dv=%b sel=%0d pulse=%b",
                         i, dout, dout_valid, cur_sel, switch_pulse, m_dout, m_dv, m_sel, m_pulse);
            end else n_pass++;
        end
        step   = 1'b0;
        pin_en = 1'b0;
    endtask

    initial begin
        model_reset();
        rst_n     = 1'b0;
        src_valid = 4'b0000;
        src_data  = '0;
        step      = 1'b0;
        pin_en    = 1'b0;
        pin_sel   = 2'd0;
        test_reset();
        test_rotation();
        test_step();
        test_invalidation();
        test_pin();
        test_live_data();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
